// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, issues word addresses to imem and queues returns with their PCs.
// Optional combinational bypass of an empty prefetch FIFO with `define IFU_BYPASS_EN.
module instruction_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  output logic [31:0]             imem_address,
  input  logic [31:0]             imem_instruction,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_pc,
  output logic                    inst_valid,
  input  logic                    inst_ready,
  output logic [31:0]             inst_data,
  output logic [31:0]             inst_pc,
  output logic [$clog2(DEPTH):0]  fill_level
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  entry_t          fifo_q [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            inflight;
  logic [31:0]     issued_pc;
  logic [PW+1:0]   occupancy;
  logic            issue, push, pop, bypass;

  // Credit: an address is issued only if its return is guaranteed a FIFO slot.
  assign occupancy = {1'b0, count} + {{(PW+1){1'b0}}, inflight};
  assign issue     = occupancy < (PW+2)'(DEPTH);

`ifdef IFU_BYPASS_EN
  assign bypass = (count == '0) && inflight && !redirect_valid;
`else
  assign bypass = 1'b0;
`endif

  assign inst_valid = (count != '0) || bypass;
  assign inst_data  = bypass ? imem_instruction : fifo_q[rd_ptr].data;
  assign inst_pc    = bypass ? issued_pc        : fifo_q[rd_ptr].pc;
  assign pop        = inst_valid && inst_ready && !bypass;
  // A bypassed return that decode accepts never lands in the FIFO.
  assign push       = inflight && !(bypass && inst_ready);
  assign fill_level = count;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      imem_address <= RESET_PC;
      inflight     <= 1'b0;
      issued_pc    <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else if (redirect_valid) begin
      // Clearing inflight drops the pre-redirect return arriving next cycle.
      imem_address <= redirect_pc;
      inflight     <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        issued_pc    <= imem_address;
        imem_address <= imem_address + 32'd1;
      end
      if (push) begin
        fifo_q[wr_ptr] <= '{pc: issued_pc, data: imem_instruction};
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge CLK) disable iff (!RST_N)
    !(push && !redirect_valid && count == (PW+1)'(DEPTH)));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed + random bench for instruction_fetch_unit; reference model is the expected PC stream seen by decode.
module tb_instruction_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'd0;
`ifdef IFU_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic                    CLK = 1'b0;
  logic                    RST_N = 1'b0;
  logic [31:0]             imem_address;
  logic [31:0]             imem_instruction = '0;
  logic                    redirect_valid = 1'b0;
  logic [31:0]             redirect_pc = '0;
  logic                    inst_valid;
  logic                    inst_ready = 1'b0;
  logic [31:0]             inst_data;
  logic [31:0]             inst_pc;
  logic [$clog2(DEPTH):0]  fill_level;

  instruction_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .imem_address(imem_address), .imem_instruction(imem_instruction),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .fill_level(fill_level)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  // Synchronous instruction memory: data for the sampled address arrives next cycle.
  always @(posedge CLK) imem_instruction <= mem_word(imem_address);

  int          checks = 0, failures = 0;
  logic [31:0] exp_pc;      // next PC decode must see
  int          pops, tick_no, first_pop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    pops = 0; tick_no = 0; first_pop = -1;
  endtask

  // One clock: drive at negedge, sample 1ns later, advance model, wait for next negedge.
  task automatic tick(input logic rdy, input logic rv, input logic [31:0] rpc);
    inst_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    #1;
    check("fill_bound", 32'(fill_level <= DEPTH), 32'd1);
    if (inst_valid) begin
      check("head_pc", inst_pc, exp_pc);
      check("head_data", inst_data, mem_word(exp_pc));
      if (rdy) begin
        exp_pc = exp_pc + 32'd1;
        pops++;
        if (first_pop < 0) first_pop = tick_no;
      end
    end
    if (rv) exp_pc = rpc;
    tick_no++;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST_N = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    exp_pc = RESET_PC;
    mark();
  endtask

  initial begin
    exp_pc = RESET_PC;
    mark();
    @(negedge CLK); #1;
    check("rst_addr", imem_address, RESET_PC);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_fill", 32'(fill_level), 32'd0);
    check("rst_data", inst_data, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    @(negedge CLK);

    // Streaming after reset
    do_reset();
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, '0);
    check("stream_first", 32'(first_pop), 32'(LAT));
    check("stream_pops", 32'(pops), 32'(12 - LAT));

    // Stall until full, then release
    do_reset();
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, '0);
    check("stall_fill", 32'(fill_level), 32'(DEPTH));
    check("stall_addr", imem_address, 32'd4);
    mark();
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, '0);
    check("release_pops", 32'(pops), 32'd8);
    check("release_next", exp_pc, 32'd8);

    // Redirect with 3 buffered and one in flight
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, '0);
    check("pre_redir_fill", 32'(fill_level), 32'd3);
    tick(1'b0, 1'b1, 32'h40);
    check("redir_addr", imem_address, 32'h40);
    check("redir_fill", 32'(fill_level), 32'd0);
    mark();
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, '0);
    check("redir_first", 32'(first_pop), 32'(LAT));
    check("redir_next", exp_pc, 32'h40 + 32'(6 - LAT));

    // Redirect coinciding with accepted pop of PC 5
    do_reset();
    for (int i = 0; i < 5 + LAT; i++) tick(1'b1, 1'b0, '0);
    check("pop5_before", 32'(pops), 32'd5);
    tick(1'b1, 1'b1, 32'h200);
    check("pop5_once", 32'(pops), 32'd6);
    mark();
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, '0);
    check("pop5_first", 32'(first_pop), 32'(LAT));
    check("pop5_next", exp_pc, 32'h200 + 32'(6 - LAT));

    // Redirect across the 32-bit wrap
    tick(1'b1, 1'b1, 32'hFFFF_FFFE);
    mark();
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b0, '0);
    check("wrap_first", 32'(first_pop), 32'(LAT));
    check("wrap_next", exp_pc, 32'hFFFF_FFFE + 32'(7 - LAT));

    // Async reset with a full FIFO
    do_reset();
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, '0);
    check("full_before_rst", 32'(fill_level), 32'(DEPTH));
    #2 RST_N = 1'b0;
    #1;
    check("arst_fill", 32'(fill_level), 32'd0);
    check("arst_valid", 32'(inst_valid), 32'd0);
    check("arst_addr", imem_address, RESET_PC);
    check("arst_pc", inst_pc, 32'd0);
    check("arst_data", inst_data, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    exp_pc = RESET_PC;
    mark();
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, '0);
    check("arst_first", 32'(first_pop), 32'(LAT));
    check("arst_pops", 32'(pops), 32'(6 - LAT));

    // Random ready / redirect traffic against the PC-stream model
    mark();
    for (int i = 0; i < 400; i++) begin
      logic        rdy, rv;
      logic [31:0] tgt;
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 19) == 0);
      tgt = ($urandom_range(0, 1) == 0) ? $urandom : 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      tick(rdy, rv, tgt);
    end
    check("rand_progress", 32'(pops >= 100), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
